// File: rtl/branch_target_buffer.sv
// Purpose : direct-mapped BTB with 2-bit direction counters; predicts fetch next-PC, resolves execute redirects.
// Latency : lookup and mispredict/redirect are combinational (0 cycles); updates become visible the next cycle.
// Backpr. : none -- one lookup and one update are accepted every cycle, flush_btb drops a same-cycle update.
//
// Ports:
//   clk, rst (async, active-low)       clock / reset; reset clears all valid bits and sets counters to WNT
//   flush_btb                          synchronous invalidate of all entries (counters keep their value)
//   pc_f -> pred_taken_f, pred_pc_f    fetch-side lookup
//   upd_*_e                            resolved branch/jump from execute (writes the table at the clock edge)
//   mispredict_e, redirect_pc_e        redirect request for the hazard unit
// Optional: define BTB_STATS_EN to add 32-bit saturating counters stat_lookups, stat_hits, stat_mispredicts.

module branch_target_buffer #(
    parameter int         DATA_WIDTH    = 32,
    parameter int         ENTRIES       = 16,   // power of 2, >= 2
    parameter int         INDEX_WIDTH   = $clog2(ENTRIES),
    parameter int         TAG_WIDTH     = DATA_WIDTH - INDEX_WIDTH - 2,
    parameter logic [1:0] JUMP_INIT_CTR = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_btb,
    input  logic [DATA_WIDTH-1:0] pc_f,
    output logic                  pred_taken_f,
    output logic [DATA_WIDTH-1:0] pred_pc_f,
    input  logic                  upd_valid_e,
    input  logic                  upd_is_jump_e,
    input  logic [DATA_WIDTH-1:0] upd_pc_e,
    input  logic                  upd_taken_e,
    input  logic [DATA_WIDTH-1:0] upd_target_e,
    input  logic                  upd_pred_taken_e,
    input  logic [DATA_WIDTH-1:0] upd_pred_pc_e,
    output logic                  mispredict_e,
    output logic [DATA_WIDTH-1:0] redirect_pc_e
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]           stat_lookups,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_mispredicts
`endif
);

    // Counter encodings: SNT=00, WNT=01, WT=10, ST=11; the MSB is the prediction.
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic                  valid_q  [ENTRIES];
    logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];

    // ------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] f_idx;
    logic [TAG_WIDTH-1:0]   f_tag;
    logic                   f_hit;

    // pc bits [1:0] take no part in index or tag, so unaligned PCs alias their word.
    assign f_idx = pc_f[INDEX_WIDTH+1:2];
    assign f_tag = pc_f[DATA_WIDTH-1:INDEX_WIDTH+2];
    // Short-circuit on valid keeps never-written tags from leaking X into the hit.
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign pred_taken_f = f_hit & ctr_q[f_idx][1];
    assign pred_pc_f    = pred_taken_f ? target_q[f_idx] : (pc_f + PC_STEP);

    // ------------------------------------------------------------------
    // Execute-side mispredict / redirect
    // ------------------------------------------------------------------
    // A taken prediction with a stale target is a mispredict even when the
    // direction was right; a correct not-taken needs no target compare.
    assign mispredict_e  = upd_valid_e &
                           ((upd_taken_e != upd_pred_taken_e) |
                            (upd_taken_e & (upd_target_e != upd_pred_pc_e)));
    assign redirect_pc_e = upd_taken_e ? upd_target_e : (upd_pc_e + PC_STEP);

    // ------------------------------------------------------------------
    // Update decision for the entry selected by upd_pc_e
    // ------------------------------------------------------------------
    logic [INDEX_WIDTH-1:0] u_idx;
    logic [TAG_WIDTH-1:0]   u_tag;
    logic                   u_hit;
    logic [1:0]             u_ctr;

    assign u_idx = upd_pc_e[INDEX_WIDTH+1:2];
    assign u_tag = upd_pc_e[DATA_WIDTH-1:INDEX_WIDTH+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_ctr = ctr_q[u_idx];

    logic       wr_ctr_en;    // counter of u_idx is written
    logic       wr_alloc;     // valid/tag of u_idx are (re)written
    logic       wr_tgt_en;    // target of u_idx is written
    logic [1:0] wr_ctr_d;

    always_comb begin
        wr_ctr_en = 1'b0;
        wr_alloc  = 1'b0;
        wr_tgt_en = 1'b0;
        wr_ctr_d  = u_ctr;
        if (upd_valid_e && !flush_btb) begin
            if (u_hit) begin
                wr_ctr_en = 1'b1;
                if (upd_is_jump_e) begin
                    wr_ctr_d  = CTR_ST;
                    wr_tgt_en = 1'b1;
                end else if (upd_taken_e) begin
                    wr_ctr_d  = (u_ctr == CTR_ST) ? CTR_ST : (u_ctr + 2'd1);
                    wr_tgt_en = 1'b1;
                end else begin
                    wr_ctr_d  = (u_ctr == 2'b00) ? 2'b00 : (u_ctr - 2'd1);
                end
            end else if (upd_taken_e) begin
                // Miss: evict whatever lives at this index.
                wr_ctr_en = 1'b1;
                wr_alloc  = 1'b1;
                wr_tgt_en = 1'b1;
                wr_ctr_d  = upd_is_jump_e ? JUMP_INIT_CTR : CTR_WT;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // valid and ctr carry architectural reset values; flush clears valid only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (flush_btb) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            if (wr_alloc) begin
                valid_q[u_idx] <= 1'b1;
            end
            if (wr_ctr_en) begin
                ctr_q[u_idx] <= wr_ctr_d;
            end
        end
    end

    // Tag and target are only meaningful under valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_alloc) begin
            tag_q[u_idx] <= u_tag;
        end
        if (wr_tgt_en) begin
            target_q[u_idx] <= upd_target_e;
        end
    end

`ifdef BTB_STATS_EN
    // ------------------------------------------------------------------
    // Optional statistics: saturating, cleared by reset and flush_btb
    // ------------------------------------------------------------------
    logic [31:0] stat_lookups_q,     stat_lookups_d;
    logic [31:0] stat_hits_q,        stat_hits_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_lookups_d     = stat_lookups_q;
        stat_hits_d        = stat_hits_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (upd_valid_e && (stat_lookups_q != 32'hFFFF_FFFF)) begin
            stat_lookups_d = stat_lookups_q + 32'd1;
        end
        if (upd_valid_e && u_hit && (stat_hits_q != 32'hFFFF_FFFF)) begin
            stat_hits_d = stat_hits_q + 32'd1;
        end
        if (mispredict_e && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_lookups_q     <= 32'd0;
            stat_hits_q        <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else if (flush_btb) begin
            stat_lookups_q     <= 32'd0;
            stat_hits_q        <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_hits_q        <= stat_hits_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_hits        = stat_hits_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Purpose : self-checking bench for branch_target_buffer (default 32-bit, 16 entries).
// Latency : outputs are combinational; each vector is driven at negedge, checked 1 time unit later.
// Backpr. : none; the bench drives one lookup/update per cycle.

module tb_branch_target_buffer;

    logic        clk;
    logic        rst;
    logic        flush_btb;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_pc_f;
    logic        upd_valid_e;
    logic        upd_is_jump_e;
    logic [31:0] upd_pc_e;
    logic        upd_taken_e;
    logic [31:0] upd_target_e;
    logic        upd_pred_taken_e;
    logic [31:0] upd_pred_pc_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
    logic [31:0] stat_mispredicts;
`endif

    branch_target_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .flush_btb        (flush_btb),
        .pc_f             (pc_f),
        .pred_taken_f     (pred_taken_f),
        .pred_pc_f        (pred_pc_f),
        .upd_valid_e      (upd_valid_e),
        .upd_is_jump_e    (upd_is_jump_e),
        .upd_pc_e         (upd_pc_e),
        .upd_taken_e      (upd_taken_e),
        .upd_target_e     (upd_target_e),
        .upd_pred_taken_e (upd_pred_taken_e),
        .upd_pred_pc_e    (upd_pred_pc_e),
        .mispredict_e     (mispredict_e),
        .redirect_pc_e    (redirect_pc_e)
`ifdef BTB_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_hits        (stat_hits),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        fl;
        logic [31:0] pc;
        logic        uv;
        logic        uj;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uppc;
        logic        ept;
        logic [31:0] epp;
        logic        emp;
        logic [31:0] erd;
    } vec_t;

    typedef struct {
        string       name;
        logic        ept;
        logic [31:0] epp;
        logic        emp;
        logic [31:0] erd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t lk(string nm, logic [31:0] pc, logic ept, logic [31:0] epp);
        vec_t v;
        v.name = nm; v.fl = 1'b0; v.pc = pc;
        v.uv = 1'b0; v.uj = 1'b0; v.upc = 32'h0; v.ut = 1'b0; v.utgt = 32'h0;
        v.upt = 1'b0; v.uppc = 32'h0;
        v.ept = ept; v.epp = epp; v.emp = 1'b0; v.erd = 32'h0;
        return v;
    endfunction

    function automatic vec_t up(string nm, logic fl, logic [31:0] pc, logic ept, logic [31:0] epp,
                                logic uj, logic [31:0] upc, logic ut, logic [31:0] utgt,
                                logic upt, logic [31:0] uppc, logic emp, logic [31:0] erd);
        vec_t v;
        v.name = nm; v.fl = fl; v.pc = pc;
        v.uv = 1'b1; v.uj = uj; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.upt = upt; v.uppc = uppc;
        v.ept = ept; v.epp = epp; v.emp = emp; v.erd = erd;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        exp_t e;
        flush_btb        = v.fl;
        pc_f             = v.pc;
        upd_valid_e      = v.uv;
        upd_is_jump_e    = v.uj;
        upd_pc_e         = v.upc;
        upd_taken_e      = v.ut;
        upd_target_e     = v.utgt;
        upd_pred_taken_e = v.upt;
        upd_pred_pc_e    = v.uppc;
        e.name = v.name; e.ept = v.ept; e.epp = v.epp; e.emp = v.emp; e.erd = v.erd;
        sb.push_back(e);
    endtask

    task automatic push_exp(string nm, logic ept, logic [31:0] epp, logic emp, logic [31:0] erd);
        exp_t e;
        e.name = nm; e.ept = ept; e.epp = epp; e.emp = emp; e.erd = erd;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries, expected >= 1");
            return;
        end
        n_tests--;
        e = sb.pop_front();
        chk({e.name, ".pred_taken"}, {31'b0, pred_taken_f}, {31'b0, e.ept});
        chk({e.name, ".pred_pc"},    pred_pc_f,              e.epp);
        chk({e.name, ".mispredict"}, {31'b0, mispredict_e},  {31'b0, e.emp});
        if (e.emp) chk({e.name, ".redirect"}, redirect_pc_e, e.erd);
    endtask

    task automatic idle();
        vec_t v;
        v = lk("idle", 32'h0, 1'b0, 32'h4);
        flush_btb = v.fl; upd_valid_e = v.uv; upd_taken_e = v.ut;
        upd_is_jump_e = v.uj; upd_pred_taken_e = v.upt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // -------- vector table --------
        vecs.push_back(lk("rst_lookup", 32'h40, 1'b0, 32'h44));
        vecs.push_back(up("alloc_br", 0, 32'h100, 0, 32'h104, 0, 32'h100, 1, 32'h80, 0, 32'h104, 1, 32'h80));
        vecs.push_back(lk("hit_wt", 32'h100, 1'b1, 32'h80));
        vecs.push_back(up("nt1", 0, 32'h100, 1, 32'h80, 0, 32'h100, 0, 32'h0, 1, 32'h80, 1, 32'h104));
        vecs.push_back(lk("after_nt1", 32'h100, 1'b0, 32'h104));
        vecs.push_back(up("nt2", 0, 32'h100, 0, 32'h104, 0, 32'h100, 0, 32'h0, 0, 32'h104, 0, 32'h0));
        vecs.push_back(up("nt3_sat", 0, 32'h100, 0, 32'h104, 0, 32'h100, 0, 32'h0, 0, 32'h104, 0, 32'h0));
        vecs.push_back(up("t_from_snt", 0, 32'h100, 0, 32'h104, 0, 32'h100, 1, 32'h80, 0, 32'h104, 1, 32'h80));
        vecs.push_back(lk("sat_check", 32'h100, 1'b0, 32'h104));
        vecs.push_back(up("t_newtgt", 0, 32'h100, 0, 32'h104, 0, 32'h100, 1, 32'h88, 0, 32'h104, 1, 32'h88));
        vecs.push_back(lk("tgt_rewrite", 32'h100, 1'b1, 32'h88));
        vecs.push_back(up("alias_alloc", 0, 32'h140, 0, 32'h144, 0, 32'h140, 1, 32'h300, 0, 32'h144, 1, 32'h300));
        vecs.push_back(lk("evicted", 32'h100, 1'b0, 32'h104));
        vecs.push_back(lk("alias_hit", 32'h140, 1'b1, 32'h300));
        vecs.push_back(up("jal_alloc", 0, 32'h204, 0, 32'h208, 1, 32'h204, 1, 32'h400, 0, 32'h208, 1, 32'h400));
        vecs.push_back(lk("jal_hit", 32'h204, 1'b1, 32'h400));
        vecs.push_back(up("jal_badtgt", 0, 32'h204, 1, 32'h400, 1, 32'h204, 1, 32'h500, 1, 32'h400, 1, 32'h500));
        vecs.push_back(up("jal_ok", 0, 32'h204, 1, 32'h500, 1, 32'h204, 1, 32'h500, 1, 32'h500, 0, 32'h0));
        vecs.push_back(lk("unaligned", 32'h206, 1'b1, 32'h500));
        vecs.push_back(up("miss_nt", 0, 32'h300, 0, 32'h304, 0, 32'h300, 0, 32'h0, 0, 32'h304, 0, 32'h0));
        vecs.push_back(lk("miss_nt_chk", 32'h300, 1'b0, 32'h304));
        vecs.push_back(lk("miss_nt_keep", 32'h140, 1'b1, 32'h300));
        v = up("uv0", 0, 32'h180, 0, 32'h184, 0, 32'h180, 1, 32'h600, 0, 32'h184, 0, 32'h0);
        v.uv = 1'b0;
        vecs.push_back(v);
        vecs.push_back(lk("uv0_noupd", 32'h180, 1'b0, 32'h184));
        vecs.push_back(lk("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0));
        vecs.push_back(up("flush_upd", 1, 32'h140, 1, 32'h300, 0, 32'h200, 1, 32'h700, 0, 32'h204, 1, 32'h700));
        vecs.push_back(lk("flush_200", 32'h200, 1'b0, 32'h204));
        vecs.push_back(lk("flush_140", 32'h140, 1'b0, 32'h144));
        vecs.push_back(lk("flush_204", 32'h204, 1'b0, 32'h208));

        // -------- reset state --------
        rst = 1'b0;
        v = lk("reset", 32'h40, 1'b0, 32'h44);
        drive(v);
        #3;
        check_out();
        @(negedge clk);
        rst = 1'b1;

        // -------- table --------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_out();
        end

        // -------- asynchronous reset mid-stream --------
        @(negedge clk);
        drive(up("re_alloc", 0, 32'h100, 0, 32'h104, 0, 32'h100, 1, 32'h80, 0, 32'h104, 1, 32'h80));
        #1;
        check_out();
        @(negedge clk);
        drive(lk("re_hit", 32'h100, 1'b1, 32'h80));
        #1;
        check_out();
        #2;
        rst = 1'b0;
        #1;
        push_exp("async_rst", 1'b0, 32'h104, 1'b0, 32'h0);
        check_out();
        @(negedge clk);
        rst = 1'b1;
        #1;
        push_exp("post_rst", 1'b0, 32'h104, 1'b0, 32'h0);
        check_out();

        @(negedge clk);
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
